mig_u_fetch: RTL and testbench

Instruction fetch stage of the Mig-U core; directly upstream of decode/execute inside the core.
- After reset, generates word-aligned instruction memory read requests starting at rst_addr.
- Buffers in-order 32-bit responses in a small FIFO and presents them, with PC, to decode over a valid/ready interface.
- Accepts a redirect from execute; stale in-flight responses are discarded.

---
 rtl/mig_u_pkg.sv | 13 +
 rtl/mig_u_fifo.sv | 60 ++++++
 rtl/mig_u_fetch.sv | 140 ++++++++++++++
 tb/tb_mig_u_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_u_pkg.sv
// Shared types and constants for the Mig-U core front end.
package mig_u_pkg;

  localparam int INSN_SIZE      = 4;
  localparam int INSN_SIZE_BITS = 32;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/mig_u_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from storage
// so the output side is registered state only.
module mig_u_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush wins over any push/pop that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mig_u_fetch.sv
// Mig-U instruction fetch: issues word-aligned requests, buffers in-order
// responses with their PC, and handles redirects by dropping stale responses.
module mig_u_fetch
  import mig_u_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-3:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [31:0]           insn_data,
  output logic [ADDR_WIDTH-3:0] insn_pc,
  output logic                  insn_fault,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr
);

  localparam int PC_W  = ADDR_WIDTH - 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSN_SIZE_BITS-1:0] insn;
    logic [PC_W-1:0]           pc;
    logic                      fault;
  } fetch_entry_t;

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  rsp_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             redirect;
  logic             credit_ok;
  logic             req_hs;
  logic             rsp_push;
  logic             insn_pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign redirect   = redirect_valid && (state != BOOT);
  assign credit_ok  = !fifo_full &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH));
  assign req_hs     = imem_req_valid && imem_req_ready;
  assign rsp_push   = imem_rsp_valid && (drop == '0) && !redirect;
  assign insn_pop   = !fifo_empty && insn_ready;
  assign push_entry = '{insn: imem_rsp_data, pc: rsp_pc, fault: imem_rsp_err};

  assign imem_req_addr = pc;
  assign insn_valid    = !fifo_empty;
  assign insn_data     = head.insn;
  assign insn_pc       = head.pc;
  assign insn_fault    = head.fault;

  // State register; reset parks the fetcher in BOOT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_next;
  end

  // Next state and request valid; a redirect always restarts fetching.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        imem_req_valid = credit_ok;
        if (rsp_push && imem_rsp_err) state_next = HALT;
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
    if (redirect) state_next = RUN;
  end

  // Outstanding request count after this cycle's handshake and response.
  always_comb begin
    inflight_next = inflight;
    case ({req_hs, imem_rsp_valid})
      2'b10:   inflight_next = inflight + 1'b1;
      2'b01:   inflight_next = inflight - 1'b1;
      default: inflight_next = inflight;
    endcase
  end

  // Request/response PCs and the credits still owed by stale responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      rsp_pc   <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (state == BOOT) begin
        pc     <= rst_addr;
        rsp_pc <= rst_addr;
      end else if (redirect) begin
        pc     <= redirect_addr;
        rsp_pc <= redirect_addr;
      end else begin
        if (req_hs)   pc     <= pc + 1'b1;
        if (rsp_push) rsp_pc <= rsp_pc + 1'b1;
      end
      if (redirect) drop <= inflight_next;
      else if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  mig_u_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_insn_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_push),
    .push_data(push_entry),
    .pop      (insn_pop),
    .flush    (redirect),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_mig_u_fetch.sv
// Randomised bench for mig_u_fetch: an in-order memory model and an
// epoch-style reference of the delivered instruction stream feed a scoreboard.
module tb_mig_u_fetch;

  localparam int AW    = 16;
  localparam int PW    = AW - 2;
  localparam int DEPTH = 2;
  localparam logic [PW-1:0] BOOT_ADDR = 14'h0400;
  localparam logic [PW-1:0] TOP_ADDR  = '1;

  logic          clk;
  logic          rst;
  logic [PW-1:0] rst_addr;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [PW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          imem_rsp_err;
  logic          insn_valid;
  logic          insn_ready;
  logic [31:0]   insn_data;
  logic [PW-1:0] insn_pc;
  logic          insn_fault;
  logic          redirect_valid;
  logic [PW-1:0] redirect_addr;

  mig_u_fetch #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rst_addr      (rst_addr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn_data     (insn_data),
    .insn_pc       (insn_pc),
    .insn_fault    (insn_fault),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] addr;
    logic [31:0]   data;
    bit            err;
    bit            stale;
  } mem_req_t;

  typedef struct {
    logic [PW-1:0] pc;
    logic [31:0]   data;
    logic          fault;
  } exp_t;

  mem_req_t memq[$];
  exp_t     expq[$];

  int checks;
  int errors;

  logic [PW-1:0] model_pc;
  bit            booting;
  bit            halted;

  int            p_req_ready;
  int            p_insn_ready;
  int            p_rsp;
  int            p_redirect;
  int            p_err;
  bit            force_redirect;
  logic [PW-1:0] force_addr;
  bit            err_on;
  logic [PW-1:0] err_addr;

  function automatic bit chance(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setKnobs(input int rr, input int ir, input int rs, input int rd, input int er);
    p_req_ready  = rr;
    p_insn_ready = ir;
    p_rsp        = rs;
    p_redirect   = rd;
    p_err        = er;
  endtask

  task automatic idleInputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    insn_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
  endtask

  task automatic resetModel();
    memq.delete();
    expq.delete();
    booting  = 1'b1;
    halted   = 1'b0;
    model_pc = '0;
  endtask

  // One cycle: compare against the model, pick inputs for the coming edge,
  // then advance the model to what that edge should do.
  task automatic applyStimulus();
    bit            do_redirect;
    bit            rsp_now;
    bit            req_hs;
    bit            pop_now;
    logic [PW-1:0] raddr;
    mem_req_t      m;
    mem_req_t      r;
    exp_t          e;

    checkOutput("insn_valid", 64'(insn_valid), 64'(expq.size() != 0));
    checkOutput("req_valid", 64'(imem_req_valid),
                64'(!booting && !halted && (memq.size() + expq.size() < DEPTH)));

    do_redirect = !booting && (force_redirect || chance(p_redirect));
    if (force_redirect) raddr = force_addr;
    else if (chance(25)) raddr = TOP_ADDR - 1'b1;
    else raddr = PW'($urandom);
    force_redirect = 1'b0;

    redirect_valid = do_redirect;
    redirect_addr  = raddr;
    insn_ready     = chance(p_insn_ready);
    imem_req_ready = chance(p_req_ready);
    rsp_now        = (memq.size() != 0) && chance(p_rsp);
    imem_rsp_valid = rsp_now;
    if (rsp_now) begin
      imem_rsp_data = memq[0].data;
      imem_rsp_err  = memq[0].err;
    end else begin
      imem_rsp_data = $urandom;
      imem_rsp_err  = 1'($urandom_range(1));
    end
    req_hs  = imem_req_valid && imem_req_ready;
    pop_now = insn_valid && insn_ready;

    if (req_hs) begin
      checkOutput("req_addr", 64'(imem_req_addr), 64'(model_pc));
      m.addr  = model_pc;
      m.data  = $urandom;
      m.err   = chance(p_err) || (err_on && (model_pc == err_addr));
      m.stale = 1'b0;
    end
    if (rsp_now) begin
      r = memq.pop_front();
      if (!r.stale && !do_redirect) begin
        e.pc    = r.addr;
        e.data  = r.data;
        e.fault = r.err;
        expq.push_back(e);
        if (r.err) halted = 1'b1;
      end
    end
    if (req_hs) begin
      memq.push_back(m);
      model_pc = model_pc + 1'b1;
    end
    if (do_redirect) begin
      for (int i = 0; i < memq.size(); i++) begin
        r = memq[i];
        r.stale = 1'b1;
        memq[i] = r;
      end
      if (pop_now) begin
        while (expq.size() > 1) void'(expq.pop_back());
      end else begin
        expq.delete();
      end
      model_pc = raddr;
      halted   = 1'b0;
    end
    if (booting) begin
      booting  = 1'b0;
      model_pc = BOOT_ADDR;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      applyStimulus();
      @(negedge clk);
    end
  endtask

  // Monitor: whenever decode takes an instruction, it must be the next one expected.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && insn_valid && insn_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_insn actual pc=%0h required none at %0t", insn_pc, $time);
        end else begin
          e = expq.pop_front();
          checkOutput("insn_data_pc_fault", 64'({insn_data, insn_pc, insn_fault}),
                      64'({e.data, e.pc, e.fault}));
        end
      end
    end
  end

  initial begin
    checks         = 0;
    errors         = 0;
    force_redirect = 1'b0;
    force_addr     = '0;
    err_on         = 1'b0;
    err_addr       = '0;
    rst            = 1'b0;
    rst_addr       = BOOT_ADDR;
    idleInputs();
    resetModel();
    setKnobs(100, 100, 100, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("reset_req_valid", 64'(imem_req_valid), 64'(0));
    checkOutput("reset_insn_valid", 64'(insn_valid), 64'(0));
    checkOutput("reset_insn_fault", 64'(insn_fault), 64'(0));
    rst = 1'b1;

    $display("[TB] streaming from boot address");
    runCycles(14);

    $display("[TB] memory back-pressure");
    p_req_ready = 0;
    runCycles(5);
    p_req_ready = 100;
    runCycles(4);

    $display("[TB] decode back-pressure");
    p_insn_ready = 0;
    runCycles(8);
    p_insn_ready = 100;
    runCycles(6);

    $display("[TB] redirect with requests in flight");
    p_rsp = 0;
    runCycles(4);
    force_redirect = 1'b1;
    force_addr     = 14'h0800;
    p_rsp          = 100;
    runCycles(10);

    $display("[TB] fetch fault then recovery");
    err_on         = 1'b1;
    err_addr       = 14'h0401;
    force_redirect = 1'b1;
    force_addr     = 14'h0400;
    runCycles(12);
    err_on         = 1'b0;
    force_redirect = 1'b1;
    force_addr     = 14'h0100;
    runCycles(10);

    $display("[TB] address wrap");
    force_redirect = 1'b1;
    force_addr     = TOP_ADDR - 1'b1;
    runCycles(8);

    $display("[TB] random traffic");
    setKnobs(70, 70, 60, 4, 3);
    runCycles(2000);

    $display("[TB] reset mid-burst");
    setKnobs(100, 100, 100, 0, 0);
    runCycles(6);
    idleInputs();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_req_valid", 64'(imem_req_valid), 64'(0));
    checkOutput("midreset_insn_valid", 64'(insn_valid), 64'(0));
    checkOutput("midreset_insn_fault", 64'(insn_fault), 64'(0));
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    runCycles(20);

    $display("[TB] draining");
    p_req_ready = 0;
    for (int i = 0; i < 100 && (memq.size() != 0 || expq.size() != 0); i++) runCycles(1);
    checkOutput("drain_left", 64'(memq.size() + expq.size()), 64'(0));
    idleInputs();
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
